// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with registered result and ARM-style N/Z/C/V flags.
// Single-cycle ops retire one cycle after transfer; MUL is an iterative
// shift-add retiring MUL_STEP multiplier bits per cycle.
module alu_pipe #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int unsigned STEPS = WIDTH / MUL_STEP;
  localparam int unsigned CW    = $clog2(STEPS + 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_ORR  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b0100;
  localparam logic [3:0] OP_ADC  = 4'b0101;
  localparam logic [3:0] OP_EOR  = 4'b0110;
  localparam logic [3:0] OP_SBC  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_SLTS = 4'b1001;

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t          state;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c;
  logic             sc_v;
  logic [WIDTH-1:0] pp;
  logic [WIDTH-1:0] acc_next;
  logic             mul_last;

  assign out_valid = (state == HOLD);
  assign in_ready  = (state == IDLE) | ((state == HOLD) & out_ready);
  assign mul_last  = (cnt == CW'(STEPS - 1));

  // Single-cycle datapath; SUB/SBC reuse the adder with inverted b so the
  // adder carry-out is directly the ARM "not borrow" C flag.
  always_comb begin
    add_b   = operand_b;
    add_cin = 1'b0;
    sc_res  = '0;
    sc_c    = carry_in;
    sc_v    = 1'b0;
    case (op)
      OP_ADC: add_cin = carry_in;
      OP_SUB: begin
        add_b   = ~operand_b;
        add_cin = 1'b1;
      end
      OP_SBC: begin
        add_b   = ~operand_b;
        add_cin = carry_in;
      end
      default: ;
    endcase
    sum = {1'b0, operand_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    case (op)
      OP_AND:  sc_res = operand_a & operand_b;
      OP_ORR:  sc_res = operand_a | operand_b;
      OP_EOR:  sc_res = operand_a ^ operand_b;
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (operand_a[WIDTH-1] == add_b[WIDTH-1]) &
                 (sum[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_SLTU: sc_res[0] = (operand_a < operand_b);
      OP_SLTS: sc_res[0] = ($signed(operand_a) < $signed(operand_b));
      default: begin
        sc_res = '0;
        sc_c   = 1'b0;
      end
    endcase
  end

  // Partial product for the MUL_STEP low multiplier bits, added to the accumulator.
  always_comb begin
    pp = '0;
    for (int unsigned i = 0; i < MUL_STEP; i++) begin
      if (mul_b[i]) pp = pp + (mul_a << i);
    end
    acc_next = acc + pp;
  end

  // Control FSM with registered result/flags and multiplier iteration state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      result <= '0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
      mul_a  <= '0;
      mul_b  <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (state == IDLE || out_ready) begin
            if (in_valid) begin
              if (op == OP_MUL) begin
                mul_a <= operand_a;
                mul_b <= operand_b;
                acc   <= '0;
                cnt   <= '0;
                state <= BUSY;
              end else begin
                result <= sc_res;
                flag_n <= sc_res[WIDTH-1];
                flag_z <= (sc_res == '0);
                flag_c <= sc_c;
                flag_v <= sc_v;
                state  <= HOLD;
              end
            end else begin
              state <= IDLE;
            end
          end
        end
        BUSY: begin
          acc   <= acc_next;
          mul_a <= mul_a << MUL_STEP;
          mul_b <= mul_b >> MUL_STEP;
          cnt   <= cnt + CW'(1);
          if (mul_last) begin
            result <= acc_next;
            flag_n <= acc_next[WIDTH-1];
            flag_z <= (acc_next == '0);
            flag_c <= 1'b0;
            flag_v <= 1'b0;
            state  <= HOLD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Testbench for alu_pipe: scoreboard of expected results plus per-feature tasks.
module tb_alu_pipe;

  localparam int unsigned WIDTH = 32;

  typedef struct packed {
    logic [31:0] r;
    logic        n;
    logic        z;
    logic        c;
    logic        v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'h0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        carry_in = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        flag_n, flag_z, flag_c, flag_v;

  logic        in_valid4 = 1'b0;
  logic        in_ready4;
  logic [3:0]  op4 = 4'h0;
  logic [31:0] operand_a4 = '0;
  logic [31:0] operand_b4 = '0;
  logic        carry_in4 = 1'b0;
  logic        out_valid4;
  logic        out_ready4 = 1'b1;
  logic [31:0] result4;
  logic        flag_n4, flag_z4, flag_c4, flag_v4;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(32), .MUL_STEP(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .operand_a(operand_a), .operand_b(operand_b), .carry_in(carry_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
  );

  alu_pipe #(.WIDTH(32), .MUL_STEP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .op(op4), .operand_a(operand_a4), .operand_b(operand_b4), .carry_in(carry_in4),
    .out_valid(out_valid4), .out_ready(out_ready4), .result(result4),
    .flag_n(flag_n4), .flag_z(flag_z4), .flag_c(flag_c4), .flag_v(flag_v4)
  );

  // Reference model built on 64-bit arithmetic rather than a WIDTH+1 adder.
  function automatic exp_t model(input logic [3:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic ci);
    exp_t        e;
    longint      sa, sb_, s;
    logic [32:0] wide;
    logic [63:0] prod;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    s   = 0;
    e.c = ci;
    e.v = 1'b0;
    case (o)
      4'd0: e.r = a & b;
      4'd1: e.r = a | b;
      4'd6: e.r = a ^ b;
      4'd2, 4'd5: begin
        wide = {1'b0, a} + {1'b0, b} + ((o == 4'd5) ? 33'(ci) : 33'd0);
        e.r  = wide[31:0];
        e.c  = wide[32];
        s    = sa + sb_ + ((o == 4'd5) ? longint'(ci) : 0);
        e.v  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd3: begin
        e.r = a - b;
        e.c = (a >= b);
        s   = sa - sb_;
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd7: begin
        e.r = a - b - (ci ? 32'd0 : 32'd1);
        e.c = ({1'b0, a} >= ({1'b0, b} + (ci ? 33'd0 : 33'd1)));
        s   = sa - sb_ - (ci ? 0 : 1);
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd4: e.r = (a < b) ? 32'd1 : 32'd0;
      4'd9: e.r = (sa < sb_) ? 32'd1 : 32'd0;
      4'd8: begin
        prod = 64'(a) * 64'(b);
        e.r  = prod[31:0];
        e.c  = 1'b0;
      end
      default: begin
        e.r = 32'd0;
        e.c = 1'b0;
      end
    endcase
    e.n = e.r[31];
    e.z = (e.r == 32'd0);
    return e;
  endfunction

  // Scoreboard: compare each retired result against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got result=%h with empty scoreboard", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({result, flag_n, flag_z, flag_c, flag_v} !== e) begin
          errors++;
          $display("FAIL sb_result got %h nzcv=%b%b%b%b exp %h nzcv=%b%b%b%b",
                   result, flag_n, flag_z, flag_c, flag_v, e.r, e.n, e.z, e.c, e.v);
        end
      end
    end
  end

  // Drive one request, wait (bounded) for acceptance, push its expectation.
  task automatic send(input logic [3:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic ci);
    int n = 0;
    op = o; operand_a = a; operand_b = b; carry_in = ci; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout got in_ready=%b exp 1", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      sb.push_back(model(o, a, b, ci));
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v} !== {1'b1, 1'b0, 32'd0, 4'b0000}) begin
      errors++;
      $display("FAIL reset got rdy=%b vld=%b res=%h nzcv=%b%b%b%b exp rdy=1 vld=0 res=0 nzcv=0000",
               in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v);
    end
  endtask

  task automatic test_arith();
    logic [3:0]  t_op [9] = '{4'd2, 4'd5, 4'd3, 4'd3, 4'd9, 4'd4, 4'd0, 4'd12, 4'd7};
    logic [31:0] t_a  [9] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd3, 32'hFFFFFFFF,
                              32'hFFFFFFFF, 32'h0000F0F0, 32'h12345678, 32'h80000000};
    logic [31:0] t_b  [9] = '{32'd1, 32'd0, 32'd5, 32'd5, 32'd1, 32'd1, 32'h00000FF0,
                              32'h1, 32'd0};
    logic        t_ci [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] t_r  [9] = '{32'h80000000, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h1, 32'h0,
                              32'h000000F0, 32'h0, 32'h7FFFFFFF};
    logic [3:0]  t_f  [9] = '{4'b1001, 4'b0110, 4'b0110, 4'b1000, 4'b0000, 4'b0100,
                              4'b0010, 4'b0100, 4'b0011};
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send(t_op[i], t_a[i], t_b[i], t_ci[i]);
      checks++;
      if ({out_valid, result, flag_n, flag_z, flag_c, flag_v} !== {1'b1, t_r[i], t_f[i]}) begin
        errors++;
        $display("FAIL arith_%0d got vld=%b res=%h nzcv=%b%b%b%b exp vld=1 res=%h nzcv=%b",
                 i, out_valid, result, flag_n, flag_z, flag_c, flag_v, t_r[i], t_f[i]);
      end
      @(posedge clk); #1;
    end
    send(4'd1, 32'hA5A50000, 32'h00005A5A, 1'b0);
    send(4'd6, 32'hFFFF0000, 32'hFF00FF00, 1'b1);
    send(4'd7, 32'd10, 32'd3, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic test_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_r);
    int  cycles = 0;
    logic bad_ready = 1'b0;
    out_ready = 1'b1;
    send(4'd8, a, b, 1'b0);
    while (!out_valid && cycles < 100) begin
      if (in_ready !== 1'b0) bad_ready = 1'b1;
      @(posedge clk); #1;
      cycles++;
    end
    checks++;
    if (cycles != 32 || bad_ready) begin
      errors++;
      $display("FAIL mul_latency got cycles=%0d busy_ready_seen=%b exp cycles=32 busy_ready_seen=0",
               cycles, bad_ready);
    end
    checks++;
    if (result !== exp_r) begin
      errors++;
      $display("FAIL mul_result got %h exp %h", result, exp_r);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mul_step4();
    int  cycles = 0;
    logic bad_ready = 1'b0;
    op4 = 4'd8; operand_a4 = 32'd12345; operand_b4 = 32'd6789; in_valid4 = 1'b1;
    @(posedge clk); #1 in_valid4 = 1'b0;
    while (!out_valid4 && cycles < 100) begin
      if (in_ready4 !== 1'b0) bad_ready = 1'b1;
      @(posedge clk); #1;
      cycles++;
    end
    checks++;
    if (cycles != 8 || bad_ready || result4 !== 32'h04FED79D || {flag_n4, flag_z4, flag_c4, flag_v4} !== 4'b0000) begin
      errors++;
      $display("FAIL mul4 got cycles=%0d busy_ready_seen=%b res=%h nzcv=%b%b%b%b exp cycles=8 0 04fed79d 0000",
               cycles, bad_ready, result4, flag_n4, flag_z4, flag_c4, flag_v4);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic bad = 1'b0;
    out_ready = 1'b0;
    send(4'd2, 32'd10, 32'd20, 1'b0);
    op = 4'd3; operand_a = 32'd100; operand_b = 32'd1; carry_in = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if ({out_valid, in_ready, result, flag_n, flag_z, flag_c, flag_v} !== {1'b1, 1'b0, 32'd30, 4'b0000})
        bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL backpressure_hold got vld=%b rdy=%b res=%h exp vld=1 rdy=0 res=0000001e",
               out_valid, in_ready, result);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_ready got in_ready=%b exp 1", in_ready);
    end
    @(posedge clk);
    sb.push_back(model(4'd3, 32'd100, 32'd1, 1'b0));
    #1 in_valid = 1'b0;
    checks++;
    if ({out_valid, result} !== {1'b1, 32'd99}) begin
      errors++;
      $display("FAIL backpressure_accept got vld=%b res=%h exp vld=1 res=00000063", out_valid, result);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_drain got out_valid=%b exp 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10};
    time t_prev = 0;
    logic gap = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(ops[$urandom_range(0, 9)], $urandom, $urandom, 1'($urandom_range(0, 1)));
      if (i > 0 && ($time - t_prev) != 10) gap = 1'b1;
      t_prev = $time;
    end
    checks++;
    if (gap) begin
      errors++;
      $display("FAIL back_to_back got gap=%b exp 0", gap);
    end
    @(posedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL back_to_back_drain got pending=%0d exp 0", sb.size());
    end
  endtask

  task automatic test_reset_mid_mul();
    out_ready = 1'b1;
    send(4'd8, 32'h13579BDF, 32'h2468ACE0, 1'b0);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, result} !== {1'b0, 1'b1, 32'd0}) begin
      errors++;
      $display("FAIL reset_mid_mul got vld=%b rdy=%b res=%h exp vld=0 rdy=1 res=0",
               out_valid, in_ready, result);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(4'd2, 32'd1, 32'd2, 1'b0);
    checks++;
    if ({out_valid, result, flag_n, flag_z, flag_c, flag_v} !== {1'b1, 32'd3, 4'b0000}) begin
      errors++;
      $display("FAIL reset_recover got vld=%b res=%h exp vld=1 res=00000003", out_valid, result);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_arith();
    test_mul(32'd12345, 32'd6789, 32'h04FED79D);
    test_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    test_mul_step4();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL final_drain got pending=%0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Handshaked, parametrised ALU that is the sequential successor to the combinational datapath ALU in the ARM7TDMI core. It accepts one operation per valid/ready transfer and returns a registered result plus ARM-style N/Z/C/V flags. Single-cycle ops complete with one-cycle latency at full throughput; MUL runs as an iterative shift-add over several cycles. It sits between the decode/operand-fetch stage and the writeback/CPSR update logic.

## Interface
Parameters:
- WIDTH, 32, operand/result width (≥ 8).
- MUL_STEP, 1, multiplier bits retired per MUL cycle; legal values 1, 2, 4; WIDTH % MUL_STEP == 0.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept; transfer when in_valid & in_ready.
- op  in  4  operation code, sampled at transfer.
- operand_a  in  WIDTH  first operand, sampled at transfer.
- operand_b  in  WIDTH  second operand, sampled at transfer.
- carry_in  in  1  CPSR C, sampled at transfer.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts; result retired when out_valid & out_ready.
- result  out  WIDTH  registered result.
- flag_n, flag_z, flag_c, flag_v  out  1 each  registered flags.

## Operation
- Opcodes: 0000 AND; 0001 ORR; 0010 ADD; 0011 SUB (a−b); 0100 SLTU (1 if a<b unsigned, else 0); 0101 ADC (a+b+carry_in); 0110 EOR; 0111 SBC (a−b−!carry_in); 1000 MUL (low WIDTH bits of a*b); 1001 SLTS (signed compare). 1010–1111: result 0, flags N=0 Z=1 C=0 V=0, single-cycle.
- Flags computed from the final result for every op: N = result[WIDTH−1]; Z = (result == 0).
- C: ADD/ADC = carry-out of bit WIDTH−1; SUB/SBC = NOT borrow (1 when no borrow, e.g. a ≥ b for SUB); AND/ORR/EOR/SLTU/SLTS = carry_in passed through; MUL = 0.
- V: ADD/ADC/SUB/SBC = signed overflow (operand signs agree per op, result sign differs); all others 0.
- Arithmetic is modulo 2^WIDTH; internal adder is WIDTH+1 bits.
- FSM states: IDLE, BUSY, HOLD.
  - IDLE: in_ready=1. On transfer with a single-cycle op, register result/flags → HOLD. With MUL, latch a, b, clear accumulator and counter → BUSY.
  - BUSY: in_ready=0. Each cycle: acc += a × b[MUL_STEP−1:0]; a <<= MUL_STEP; b >>= MUL_STEP; count++. After S = WIDTH/MUL_STEP iterations, register acc and flags → HOLD.
  - HOLD: out_valid=1; result and flags are stable while out_ready=0. On out_ready: if in_valid, accept the new op as from IDLE in the same edge; otherwise → IDLE.
- in_ready = (state==IDLE) | (state==HOLD & out_ready); this is a combinational path from out_ready.
- Operand/op changes after transfer are ignored.

## Timing
- Reset (async assert, any state, including mid-MUL): state IDLE, in_ready=1, out_valid=0, result=0, all flags=0, accumulator and counter cleared; an in-flight op is discarded. Release is synchronous to clk.
- Single-cycle op: transfer at edge k → out_valid=1 after edge k. Throughput is one op per cycle with out_ready held at 1.
- MUL: transfer at edge k → iterations at edges k+1…k+S → out_valid=1 after edge k+S (latency S: 32 for WIDTH=32, MUL_STEP=1; 8 for MUL_STEP=4).
- out_valid deasserts on the edge after retirement unless a new op is accepted on that same edge.
- in_valid while BUSY, or while HOLD with out_ready=0: no transfer, no state change.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 → 0x80000000, N=1 Z=0 C=0 V=1, out_valid one cycle after transfer; ADC 0xFFFFFFFF + 0 with carry_in=1 → 0x00000000, Z=1 C=1 V=0.
- SUB 5−5 → 0, Z=1 C=1 V=0; SUB 3−5 → 0xFFFFFFFE, N=1 C=0; SLTS 0xFFFFFFFF vs 1 → 1, SLTU same operands → 0; AND with carry_in=1 → C=1 V=0.
- MUL 12345 × 6789 → 0x04FED79D with out_valid exactly 32 cycles after transfer (MUL_STEP=1) and 8 cycles (MUL_STEP=4); 0xFFFFFFFF × 0xFFFFFFFF → 0x00000001; in_ready=0 throughout BUSY.
- Backpressure: hold out_ready=0 for 5 cycles after a result → result/flags unchanged, in_ready=0, the pending in_valid op is not taken; raise out_ready → the pending op is accepted on the same edge.
- Back-to-back: 8 single-cycle ops with in_valid and out_ready held at 1 → 8 consecutive out_valid cycles with correct in-order results.
- Assert rst_n=0 during MUL iteration 10 → out_valid=0, result=0 immediately; after release, ADD 1+2 → 3 with no residue from the aborted MUL.
